seg_scan: RTL and testbench

Multiplexed seven-segment display scanner for an N-digit common-anode display. It consumes the slow scan square wave `clk_m` from the clock generator and resynchronises it into the system clock domain, where each rising edge becomes a one-cycle scan tick. Each tick advances the lit digit, inserting a blanking gap between digits to suppress ghosting. Display data is latched once per frame, so a digit never mixes old and new values.

---
 rtl/seg_scan.sv | 183 ++++++++++++++++++
 tb/tb_seg_scan.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/seg_scan.sv
// seg_scan: N-digit multiplexed seven-segment scanner with blanking gaps.
// Ports: clk, rst_n, clk_m, data, dp_in, lzb in; an_n, seg_n, dp_n, overrun out.
module seg_scan #(
  parameter int N_DIG     = 4,
  parameter int BLANK_CYC = 50
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clk_m,
  input  logic [4*N_DIG-1:0] data,
  input  logic [N_DIG-1:0]   dp_in,
  input  logic               lzb,
  output logic [N_DIG-1:0]   an_n,
  output logic [6:0]         seg_n,
  output logic               dp_n,
  output logic               overrun
);

  localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_DIG - 1);
  localparam logic [15:0] CNT_INIT = 16'(BLANK_CYC - 1);

  typedef enum logic [1:0] {
    LOAD,
    BLANK,
    DRIVE
  } state_e;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] s;
    unique case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // m_q is the raw capture flop; s1..s3 resolve metastability and
  // provide the previous sample for rising-edge detection.
  logic m_q, s1_q, s2_q, s3_q;
  logic tick;

  state_e               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [4*N_DIG-1:0]   sh_data_q, sh_data_d;
  logic [N_DIG-1:0]     sh_dp_q, sh_dp_d;
  logic                 sh_lzb_q, sh_lzb_d;
  logic [N_DIG-1:0]     an_n_q, an_n_d;
  logic [6:0]           seg_n_q, seg_n_d;
  logic                 dp_n_q, dp_n_d;
  logic                 ovr_q, ovr_d;

  logic [3:0] dig;
  logic       nz;
  logic       supp;

  assign tick = s2_q & ~s3_q;

  // Suppress digit idx when it and all higher digits are zero.
  always_comb begin
    dig = sh_data_q[4*idx_q +: 4];
    nz  = 1'b0;
    for (int i = 0; i < N_DIG; i++) begin
      if (i >= int'(idx_q) && sh_data_q[4*i +: 4] != 4'h0) begin
        nz = 1'b1;
      end
    end
    supp = sh_lzb_q && (idx_q != '0) && !nz;
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    sh_data_d = sh_data_q;
    sh_dp_d   = sh_dp_q;
    sh_lzb_d  = sh_lzb_q;
    an_n_d    = an_n_q;
    seg_n_d   = seg_n_q;
    dp_n_d    = dp_n_q;
    ovr_d     = ovr_q;
    unique case (state_q)
      LOAD: begin
        sh_data_d = data;
        sh_dp_d   = dp_in;
        sh_lzb_d  = lzb;
        cnt_d     = CNT_INIT;
        idx_d     = '0;
        state_d   = BLANK;
        an_n_d    = '1;
        seg_n_d   = 7'h7F;
        dp_n_d    = 1'b1;
        if (tick) ovr_d = 1'b1;
      end
      BLANK: begin
        an_n_d  = '1;
        seg_n_d = 7'h7F;
        dp_n_d  = 1'b1;
        if (tick) ovr_d = 1'b1;
        if (cnt_q == 16'd0) begin
          state_d = DRIVE;
          if (!supp) begin
            an_n_d  = ~(N_DIG'(1) << idx_q);
            seg_n_d = hex7(dig);
            dp_n_d  = ~sh_dp_q[idx_q];
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DRIVE: begin
        if (tick) begin
          an_n_d  = '1;
          seg_n_d = 7'h7F;
          dp_n_d  = 1'b1;
          if (idx_q == LAST) begin
            state_d = LOAD;
          end else begin
            idx_d   = idx_q + IW'(1);
            cnt_d   = CNT_INIT;
            state_d = BLANK;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q       <= 1'b0;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      state_q   <= LOAD;
      idx_q     <= '0;
      cnt_q     <= 16'd0;
      sh_data_q <= '0;
      sh_dp_q   <= '0;
      sh_lzb_q  <= 1'b0;
      an_n_q    <= '1;
      seg_n_q   <= 7'h7F;
      dp_n_q    <= 1'b1;
      ovr_q     <= 1'b0;
    end else begin
      m_q       <= clk_m;
      s1_q      <= m_q;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      sh_data_q <= sh_data_d;
      sh_dp_q   <= sh_dp_d;
      sh_lzb_q  <= sh_lzb_d;
      an_n_q    <= an_n_d;
      seg_n_q   <= seg_n_d;
      dp_n_q    <= dp_n_d;
      ovr_q     <= ovr_d;
    end
  end

  assign an_n    = an_n_q;
  assign seg_n   = seg_n_q;
  assign dp_n    = dp_n_q;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: directed bench for seg_scan (scan, LZB, coherence,
// overrun, synchroniser latency, async reset).
module tb_seg_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clk_m;
  logic        clk_m2;
  logic [15:0] data;
  logic [3:0]  dp_in;
  logic        lzb;
  logic [3:0]  an_n, an2;
  logic [6:0]  seg_n, seg2;
  logic        dp_n, dp2;
  logic        overrun, ovr2;

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] cur_an;

  always #5 clk = ~clk;

  seg_scan #(.N_DIG(4), .BLANK_CYC(4)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clk_m   (clk_m),
    .data    (data),
    .dp_in   (dp_in),
    .lzb     (lzb),
    .an_n    (an_n),
    .seg_n   (seg_n),
    .dp_n    (dp_n),
    .overrun (overrun)
  );

  seg_scan #(.N_DIG(4), .BLANK_CYC(200)) u_ovr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clk_m   (clk_m2),
    .data    (data),
    .dp_in   (dp_in),
    .lzb     (lzb),
    .an_n    (an2),
    .seg_n   (seg2),
    .dp_n    (dp2),
    .overrun (ovr2)
  );

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag,
                         input logic [3:0] ea,
                         input logic [6:0] es,
                         input logic ed);
    chk({tag, ".an"}, {12'h0, an_n}, {12'h0, ea});
    chk({tag, ".seg"}, {9'h0, seg_n}, {9'h0, es});
    chk({tag, ".dp"}, {15'h0, dp_n}, {15'h0, ed});
  endtask

  // One-cycle clk_m pulse; edge k is the first posedge with it high.
  task automatic advance(input string tag,
                         input int gap,
                         input logic [3:0] ea,
                         input logic [6:0] es,
                         input logic ed);
    @(negedge clk);
    clk_m = 1'b1;
    @(negedge clk);
    clk_m = 1'b0;
    repeat (2) @(negedge clk);
    chk({tag, ".hold"}, {12'h0, an_n}, {12'h0, cur_an});
    @(negedge clk);
    chk_out({tag, ".k3"}, 4'hF, 7'h7F, 1'b1);
    repeat (gap - 1) @(negedge clk);
    chk_out({tag, ".gap"}, 4'hF, 7'h7F, 1'b1);
    @(negedge clk);
    chk_out({tag, ".live"}, ea, es, ed);
    cur_an = ea;
  endtask

  initial begin
    rst_n  = 1'b0;
    clk_m  = 1'b0;
    clk_m2 = 1'b0;
    data   = 16'h1234;
    dp_in  = 4'b0100;
    lzb    = 1'b0;
    repeat (2) @(negedge clk);
    chk_out("rst", 4'hF, 7'h7F, 1'b1);
    chk("rst.ovr", {15'h0, overrun}, 16'h0);

    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk_out("boot4", 4'hF, 7'h7F, 1'b1);
    @(negedge clk);
    chk_out("boot5", 4'hE, 7'h19, 1'b1);
    cur_an = 4'hE;

    advance("scan1", 4, 4'hD, 7'h30, 1'b1);
    advance("scan2", 4, 4'hB, 7'h24, 1'b0);
    advance("scan3", 4, 4'h7, 7'h79, 1'b1);
    advance("scan0", 5, 4'hE, 7'h19, 1'b1);

    advance("coh1", 4, 4'hD, 7'h30, 1'b1);
    data = 16'hABCD;
    advance("coh2", 4, 4'hB, 7'h24, 1'b0);
    advance("coh3", 4, 4'h7, 7'h79, 1'b1);
    advance("new0", 5, 4'hE, 7'h21, 1'b1);
    advance("new1", 4, 4'hD, 7'h46, 1'b1);
    advance("new2", 4, 4'hB, 7'h03, 1'b0);
    advance("new3", 4, 4'h7, 7'h08, 1'b1);

    lzb   = 1'b1;
    data  = 16'h0070;
    dp_in = 4'b0000;
    advance("lz0", 5, 4'hE, 7'h40, 1'b1);
    advance("lz1", 4, 4'hD, 7'h78, 1'b1);
    advance("lz2", 4, 4'hF, 7'h7F, 1'b1);
    advance("lz3", 4, 4'hF, 7'h7F, 1'b1);
    data  = 16'h0000;
    dp_in = 4'b1111;
    advance("zz0", 5, 4'hE, 7'h40, 1'b0);
    advance("zz1", 4, 4'hF, 7'h7F, 1'b1);
    advance("zz2", 4, 4'hF, 7'h7F, 1'b1);
    advance("zz3", 4, 4'hF, 7'h7F, 1'b1);
    advance("zzr", 5, 4'hE, 7'h40, 1'b0);
    chk("scan.ovr", {15'h0, overrun}, 16'h0);

    // Asynchronous reset while digit 0 is lit.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_out("arst", 4'hF, 7'h7F, 1'b1);
    chk("arst.ovr", {15'h0, overrun}, 16'h0);

    data  = 16'h1234;
    dp_in = 4'b0000;
    lzb   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Stray tick into the long BLANK of the second instance.
    repeat (10) @(negedge clk);
    clk_m2 = 1'b1;
    @(negedge clk);
    clk_m2 = 1'b0;
    repeat (6) @(negedge clk);
    chk("ovr.set", {15'h0, ovr2}, 16'h1);
    chk("ovr.an", {12'h0, an2}, 16'hF);
    repeat (183) @(negedge clk);
    chk("ovr.an200", {12'h0, an2}, 16'hF);
    @(negedge clk);
    chk("ovr.an201", {12'h0, an2}, 16'hE);
    chk("ovr.seg", {9'h0, seg2}, 16'h19);
    chk("ovr.stick", {15'h0, ovr2}, 16'h1);
    chk("dut.noovr", {15'h0, overrun}, 16'h0);

    // Held-high clk_m must give exactly one advance.
    chk_out("held.pre", 4'hE, 7'h19, 1'b1);
    clk_m = 1'b1;
    repeat (30) @(negedge clk);
    chk_out("held", 4'hD, 7'h30, 1'b1);
    clk_m = 1'b0;
    repeat (4) @(negedge clk);
    chk_out("held.post", 4'hD, 7'h30, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
